// File: rtl/pe_array_2d.sv
// pe_array_2d: NxN grid of PEs (A, B, signed saturating accumulator) sequenced by an ack handshake.
// Define PE_ARRAY_WRAP_EN for circular image shifts; the default build zero-fills.
module pe_array_2d #(
  parameter int unsigned ARRAY_SIZE_1D    = 2,
  parameter int unsigned EXTENSION_AMOUNT = 4,
  parameter int unsigned long_shift_amount = 4,
  parameter int unsigned PRECISION        = 8,
  parameter int unsigned OUTPUT_PRECISION = 32
) (
  input  logic CLK,
  input  logic reset,
  input  logic array_ack,
  input  logic [2:0] command_to_execute,
  input  logic image_to_shift,
  input  logic [ARRAY_SIZE_1D-1:0][ARRAY_SIZE_1D-1:0][PRECISION-1:0]        a_overwrite,
  input  logic [ARRAY_SIZE_1D-1:0][ARRAY_SIZE_1D-1:0][PRECISION-1:0]        b_overwrite,
  input  logic [ARRAY_SIZE_1D-1:0][ARRAY_SIZE_1D-1:0][OUTPUT_PRECISION-1:0] s_out_overwrite_array,
  output logic ready,
  output logic [ARRAY_SIZE_1D-1:0][ARRAY_SIZE_1D-1:0][PRECISION-1:0]        A_array,
  output logic [ARRAY_SIZE_1D-1:0][ARRAY_SIZE_1D-1:0][PRECISION-1:0]        B_array,
  output logic [ARRAY_SIZE_1D-1:0][ARRAY_SIZE_1D-1:0][OUTPUT_PRECISION-1:0] s_out_array
);

  localparam int unsigned N     = ARRAY_SIZE_1D;
  localparam int unsigned P     = PRECISION;
  localparam int unsigned OW    = OUTPUT_PRECISION;
  localparam int unsigned SAT_W = 2 * PRECISION + EXTENSION_AMOUNT;
  localparam int unsigned SUM_W = OUTPUT_PRECISION + 1;
  localparam int unsigned CNT_W = (long_shift_amount > 1) ? $clog2(long_shift_amount) : 1;

`ifdef PE_ARRAY_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  if (OUTPUT_PRECISION < 2 * PRECISION + EXTENSION_AMOUNT) begin : g_bad_output_width
    $error("pe_array_2d: OUTPUT_PRECISION narrower than the saturating accumulator width");
  end
  if (long_shift_amount < 1) begin : g_bad_long_shift
    $error("pe_array_2d: long_shift_amount must be at least 1");
  end

  // Saturation bounds of the SAT_W-bit signed range, held in the wider sum format
  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W - SAT_W + 1){1'b0}}, {(SAT_W - 1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef logic [N-1:0][N-1:0][P-1:0] img_t;

  typedef enum logic [1:0] {IDLE, ARMED, EXEC, DONE} state_t;
  typedef enum logic [2:0] {
    OP_NOP, OP_MAC, OP_SHR, OP_SHD, OP_LSHR, OP_LOAD, OP_LDACC, OP_CLR
  } op_t;

  state_t            state, state_n;
  op_t               cmd_q;
  logic              img_q;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              take;

  function automatic img_t shift_right(input img_t x);
    img_t y;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (c == 0) y[r][c] = WRAP ? x[r][N-1] : '0;
        else        y[r][c] = x[r][c-1];
      end
    end
    return y;
  endfunction

  function automatic img_t shift_down(input img_t x);
    img_t y;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (r == 0) y[r][c] = WRAP ? x[N-1][c] : '0;
        else        y[r][c] = x[r-1][c];
      end
    end
    return y;
  endfunction

  function automatic logic [OW-1:0] mac_sat(input logic signed [OW-1:0] acc,
                                            input logic signed [P-1:0]  a,
                                            input logic signed [P-1:0]  b);
    logic signed [2*P-1:0]   prod;
    logic signed [SUM_W-1:0] sum;
    prod = (2*P)'(a) * (2*P)'(b);
    sum  = SUM_W'(acc) + SUM_W'(prod);
    if (sum > SAT_MAX)      return OW'(SAT_MAX);
    else if (sum < SAT_MIN) return OW'(SAT_MIN);
    else                    return OW'(sum);
  endfunction

  // Control state register; ready tracks the upcoming IDLE state so it is a flop output
  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      ready <= 1'b1;
      cmd_q <= OP_NOP;
      img_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ready <= (state_n == IDLE);
      if (take) begin
        cmd_q <= op_t'(command_to_execute);
        img_q <= image_to_shift;
      end
    end
  end

  // Next-state: long shift stays in EXEC for long_shift_amount steps
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    take    = 1'b0;
    case (state)
      IDLE:  if (array_ack) state_n = ARMED;
      ARMED: begin
        if (!array_ack) begin
          take    = 1'b1;
          cnt_n   = '0;
          state_n = EXEC;
        end
      end
      EXEC: begin
        if (cmd_q == OP_LSHR && cnt != CNT_W'(long_shift_amount - 1)) begin
          cnt_n = cnt + CNT_W'(1);
        end else begin
          cnt_n   = '0;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // PE datapath: one step per EXEC cycle
  always_ff @(posedge CLK) begin
    if (reset) begin
      A_array     <= '0;
      B_array     <= '0;
      s_out_array <= '0;
    end else if (state == EXEC) begin
      case (cmd_q)
        OP_MAC: begin
          for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
              s_out_array[r][c] <= mac_sat(s_out_array[r][c], A_array[r][c], B_array[r][c]);
            end
          end
        end
        OP_SHR, OP_LSHR: begin
          if (img_q) B_array <= shift_right(B_array);
          else       A_array <= shift_right(A_array);
        end
        OP_SHD: begin
          if (img_q) B_array <= shift_down(B_array);
          else       A_array <= shift_down(A_array);
        end
        OP_LOAD: begin
          A_array <= a_overwrite;
          B_array <= b_overwrite;
        end
        OP_LDACC: s_out_array <= s_out_overwrite_array;
        OP_CLR:   s_out_array <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_array_2d.sv
// tb_pe_array_2d: directed table plus randomized commands checked against a plain-arithmetic model.
module tb_pe_array_2d;

  localparam int unsigned N   = 2;
  localparam int unsigned P   = 8;
  localparam int unsigned OW  = 32;
  localparam int unsigned EXT = 4;
  localparam int unsigned L   = 4;
  localparam longint SMAX = (64'sd1 <<< (2*P + EXT - 1)) - 64'sd1;
  localparam longint SMIN = -SMAX - 64'sd1;
`ifdef PE_ARRAY_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic CLK = 1'b0;
  logic reset, array_ack, image_to_shift, ready;
  logic [2:0] command_to_execute;
  logic [N-1:0][N-1:0][P-1:0]  a_overwrite, b_overwrite, A_array, B_array;
  logic [N-1:0][N-1:0][OW-1:0] s_out_overwrite_array, s_out_array;

  pe_array_2d dut (
    .CLK(CLK), .reset(reset), .array_ack(array_ack),
    .command_to_execute(command_to_execute), .image_to_shift(image_to_shift),
    .a_overwrite(a_overwrite), .b_overwrite(b_overwrite),
    .s_out_overwrite_array(s_out_overwrite_array),
    .ready(ready), .A_array(A_array), .B_array(B_array), .s_out_array(s_out_array)
  );

  always #5 CLK = ~CLK;

  typedef int q4_t [N*N];
  typedef struct {
    logic [2:0] op;
    logic       img;
    q4_t        a_in, b_in, s_in;
    q4_t        exp_a, exp_b, exp_s;
    int         exp_lat;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;
  q4_t  ma, mb, ms;
  q4_t  z, one, three, neg1, nine, e18, pmax, nmin, s1234, s5678;
  q4_t  shr_a, shd_b, lsh_a, lsh_b;

  function automatic void chk(string name, longint act, longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(logic [2:0] op, logic img, q4_t ai, q4_t bi, q4_t si,
                              q4_t ea, q4_t eb, q4_t es, int lat);
    vec_t v;
    v.op = op; v.img = img; v.a_in = ai; v.b_in = bi; v.s_in = si;
    v.exp_a = ea; v.exp_b = eb; v.exp_s = es; v.exp_lat = lat;
    return v;
  endfunction

  // Reference model: images as flat row-major arrays, shifts by index arithmetic
  function automatic q4_t move_cols(q4_t x, int k);
    q4_t y;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        int src = c - k;
        if (WRAP) y[r*N+c] = x[r*N + ((src % int'(N)) + int'(N)) % int'(N)];
        else      y[r*N+c] = (src >= 0) ? x[r*N+src] : 0;
      end
    end
    return y;
  endfunction

  function automatic q4_t move_rows(q4_t x, int k);
    q4_t y;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        int src = r - k;
        if (WRAP) y[r*N+c] = x[(((src % int'(N)) + int'(N)) % int'(N))*N + c];
        else      y[r*N+c] = (src >= 0) ? x[src*N+c] : 0;
      end
    end
    return y;
  endfunction

  function automatic void model_step(logic [2:0] op, logic img, q4_t ai, q4_t bi, q4_t si);
    case (op)
      3'd1: for (int i = 0; i < N*N; i++) begin
        longint v = longint'(ms[i]) + longint'(ma[i]) * longint'(mb[i]);
        if (v > SMAX) v = SMAX;
        if (v < SMIN) v = SMIN;
        ms[i] = int'(v);
      end
      3'd2: if (img) mb = move_cols(mb, 1); else ma = move_cols(ma, 1);
      3'd3: if (img) mb = move_rows(mb, 1); else ma = move_rows(ma, 1);
      3'd4: if (img) mb = move_cols(mb, L); else ma = move_cols(ma, L);
      3'd5: begin ma = ai; mb = bi; end
      3'd6: ms = si;
      3'd7: for (int i = 0; i < N*N; i++) ms[i] = 0;
      default: ;
    endcase
  endfunction

  task automatic drive_data(q4_t ai, q4_t bi, q4_t si);
    for (int i = 0; i < N*N; i++) begin
      a_overwrite[i/N][i%N]           = P'(ai[i]);
      b_overwrite[i/N][i%N]           = P'(bi[i]);
      s_out_overwrite_array[i/N][i%N] = OW'(si[i]);
    end
  endtask

  // Handshake one command; lat counts edges from the one sampling ack low until ready is seen
  task automatic run_cmd(logic [2:0] op, logic img, output int lat);
    @(negedge CLK);
    array_ack = 1'b1; command_to_execute = op; image_to_shift = img;
    @(negedge CLK);
    array_ack = 1'b0;
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!ready && lat < 20);
  endtask

  task automatic check_all(string tag, q4_t ea, q4_t eb, q4_t es);
    for (int i = 0; i < N*N; i++) begin
      chk($sformatf("%s A[%0d]", tag, i), longint'($signed(A_array[i/N][i%N])), ea[i]);
      chk($sformatf("%s B[%0d]", tag, i), longint'($signed(B_array[i/N][i%N])), eb[i]);
      chk($sformatf("%s S[%0d]", tag, i), longint'($signed(s_out_array[i/N][i%N])), es[i]);
    end
  endtask

  initial begin
    int lat;
    logic [2:0] op;
    logic img;
    q4_t ra, rb, rs;

    for (int i = 0; i < N*N; i++) begin
      z[i] = 0; one[i] = 1; three[i] = 3; neg1[i] = -1; nine[i] = 9; e18[i] = 18;
      pmax[i] = 524287; nmin[i] = -524288;
      s1234[i] = i + 1; s5678[i] = i + 5;
    end
`ifdef PE_ARRAY_WRAP_EN
    shr_a = '{2, 1, 4, 3}; shd_b = '{7, 8, 5, 6}; lsh_a = s1234; lsh_b = s5678;
`else
    shr_a = '{0, 1, 0, 3}; shd_b = '{0, 0, 5, 6}; lsh_a = z;     lsh_b = z;
`endif

    tbl.push_back(mk(3'd5, 1'b0, one,   one,   z,    one,   one,   z,    3));
    tbl.push_back(mk(3'd5, 1'b0, s1234, s5678, z,    s1234, s5678, z,    3));
    tbl.push_back(mk(3'd2, 1'b0, z,     z,     z,    shr_a, s5678, z,    3));
    tbl.push_back(mk(3'd3, 1'b1, z,     z,     z,    shr_a, shd_b, z,    3));
    tbl.push_back(mk(3'd0, 1'b0, z,     z,     pmax, shr_a, shd_b, z,    3));
    tbl.push_back(mk(3'd5, 1'b0, three, three, z,    three, three, z,    3));
    tbl.push_back(mk(3'd7, 1'b0, z,     z,     z,    three, three, z,    3));
    tbl.push_back(mk(3'd1, 1'b0, z,     z,     z,    three, three, nine, 3));
    tbl.push_back(mk(3'd1, 1'b0, z,     z,     z,    three, three, e18,  3));
    tbl.push_back(mk(3'd6, 1'b0, z,     z,     pmax, three, three, pmax, 3));
    tbl.push_back(mk(3'd5, 1'b0, one,   one,   z,    one,   one,   pmax, 3));
    tbl.push_back(mk(3'd1, 1'b0, z,     z,     z,    one,   one,   pmax, 3));
    tbl.push_back(mk(3'd6, 1'b0, z,     z,     nmin, one,   one,   nmin, 3));
    tbl.push_back(mk(3'd5, 1'b0, one,   neg1,  z,    one,   neg1,  nmin, 3));
    tbl.push_back(mk(3'd1, 1'b0, z,     z,     z,    one,   neg1,  nmin, 3));
    tbl.push_back(mk(3'd5, 1'b0, s1234, s5678, z,    s1234, s5678, nmin, 3));
    tbl.push_back(mk(3'd4, 1'b0, z,     z,     z,    lsh_a, s5678, nmin, 6));
    tbl.push_back(mk(3'd4, 1'b1, z,     z,     z,    lsh_a, lsh_b, nmin, 6));

    reset = 1'b1; array_ack = 1'b0; command_to_execute = 3'd0; image_to_shift = 1'b0;
    drive_data(z, z, z);
    repeat (2) @(negedge CLK);
    chk("reset ready", longint'(ready), 1);
    check_all("reset", z, z, z);
    reset = 1'b0;

    foreach (tbl[k]) begin
      drive_data(tbl[k].a_in, tbl[k].b_in, tbl[k].s_in);
      run_cmd(tbl[k].op, tbl[k].img, lat);
      chk($sformatf("vec%0d latency", k), lat, tbl[k].exp_lat);
      check_all($sformatf("vec%0d", k), tbl[k].exp_a, tbl[k].exp_b, tbl[k].exp_s);
    end
    ma = tbl[tbl.size()-1].exp_a;
    mb = tbl[tbl.size()-1].exp_b;
    ms = tbl[tbl.size()-1].exp_s;

    for (int t = 0; t < 60; t++) begin
      op  = 3'($urandom_range(0, 7));
      img = 1'($urandom_range(0, 1));
      for (int i = 0; i < N*N; i++) begin
        ra[i] = int'($urandom_range(0, 255)) - 128;
        rb[i] = int'($urandom_range(0, 255)) - 128;
        rs[i] = int'($urandom_range(0, 1200000)) - 600000;
      end
      drive_data(ra, rb, rs);
      model_step(op, img, ra, rb, rs);
      run_cmd(op, img, lat);
      chk($sformatf("rnd%0d op%0d latency", t, op), lat, (op == 3'd4) ? int'(L) + 2 : 3);
      check_all($sformatf("rnd%0d op%0d", t, op), ma, mb, ms);
    end

    // Reset while a long shift is executing
    drive_data(s1234, s5678, e18);
    run_cmd(3'd5, 1'b0, lat);
    run_cmd(3'd6, 1'b0, lat);
    check_all("pre-abort", s1234, s5678, e18);
    @(negedge CLK);
    array_ack = 1'b1; command_to_execute = 3'd4; image_to_shift = 1'b0;
    @(negedge CLK);
    array_ack = 1'b0;
    @(negedge CLK);
    chk("abort busy", longint'(ready), 0);
    reset = 1'b1;
    @(negedge CLK);
    chk("abort ready", longint'(ready), 1);
    check_all("abort", z, z, z);
    reset = 1'b0;
    @(negedge CLK);
    chk("abort idle", longint'(ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
